// File: rtl/npu_cmd_scheduler.sv
// Purpose : queues decoded SPI tile commands and issues them one at a time to the NPU tile engine.
// Latency : ENQUEUE taken at E -> count visible E+1 -> eng_start at E+2; data_out trails state by one cycle.
// Backpressure: none toward SPI; a push into a full queue is dropped and flagged in err_overflow.
//
// Ports:
//   clk, rst_n                           clock, synchronous active-low reset
//   spi_valid, cmd, tile_i, tile_j,      decoded SPI command; a rising edge of spi_valid
//   op_code, data_in                     marks one new command
//   data_out                             status byte or last engine result, returned on MISO
//   eng_start, eng_tile_i, eng_tile_j,   one-cycle issue strobe plus operation fields, which
//   eng_op, eng_operand                  hold until the next issue
//   eng_done, eng_result                 engine completion pulse and result
//   busy                                 scheduler FSM not idle
module npu_cmd_scheduler #(
   parameter int FIFO_DEPTH = 4,   // 2..7
   parameter int TIMEOUT    = 255  // 1..255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       spi_valid,
   input  logic [7:0] cmd,
   input  logic [2:0] tile_i,
   input  logic [2:0] tile_j,
   input  logic [2:0] op_code,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   output logic       eng_start,
   output logic [2:0] eng_tile_i,
   output logic [2:0] eng_tile_j,
   output logic [2:0] eng_op,
   output logic [7:0] eng_operand,
   input  logic       eng_done,
   input  logic [7:0] eng_result,
   output logic       busy
);

   localparam int              PW       = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [2:0]      DEPTH_C  = 3'(FIFO_DEPTH);
   localparam logic [PW-1:0]   LAST_PTR = PW'(FIFO_DEPTH - 1);
   // WAIT lasts exactly TIMEOUT cycles: the counter starts at 0 on WAIT entry.
   localparam logic [7:0]      TMO_LAST = 8'(TIMEOUT - 1);

   localparam logic [7:0] CMD_ENQUEUE = 8'h01;
   localparam logic [7:0] CMD_SEL_ST  = 8'h02;
   localparam logic [7:0] CMD_SEL_RES = 8'h03;
   localparam logic [7:0] CMD_FLUSH   = 8'h04;
   localparam logic [7:0] CMD_CLR_ERR = 8'h05;

   typedef struct packed {
      logic [2:0] tile_i;
      logic [2:0] tile_j;
      logic [2:0] op;
      logic [7:0] operand;
   } entry_t;

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

   state_t          state, state_nxt;
   logic            valid_q;
   logic            take;
   logic            is_enq, is_sel_st, is_sel_res, is_flush, is_clr, is_ill;
   entry_t          mem [FIFO_DEPTH];
   entry_t          entry_in, head;
   logic [PW-1:0]   rd_ptr, wr_ptr;
   logic [2:0]      count;
   logic            full;
   logic            push_ok, push_drop, pop, load_issue, wait_done, wait_tmo;
   logic            err_illegal, err_overflow, err_timeout;
   logic            sel_result;
   logic [7:0]      result_q;
   logic [7:0]      tmo_cnt;
   logic [7:0]      status;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PW'(1);
   endfunction

   // One command per rising edge of the (already synchronised) valid level.
   assign take = spi_valid & ~valid_q;

   always_comb begin
      is_enq     = 1'b0;
      is_sel_st  = 1'b0;
      is_sel_res = 1'b0;
      is_flush   = 1'b0;
      is_clr     = 1'b0;
      is_ill     = 1'b0;
      if (take) begin
         case (cmd)
            CMD_ENQUEUE: is_enq     = 1'b1;
            CMD_SEL_ST:  is_sel_st  = 1'b1;
            CMD_SEL_RES: is_sel_res = 1'b1;
            CMD_FLUSH:   is_flush   = 1'b1;
            CMD_CLR_ERR: is_clr     = 1'b1;
            default:     is_ill     = 1'b1;
         endcase
      end
   end

   assign entry_in  = {tile_i, tile_j, op_code, data_in};
   assign head      = mem[rd_ptr];
   assign full      = (count == DEPTH_C);
   assign busy      = (state != ST_IDLE);
   assign status    = {busy, full, err_illegal, err_overflow, err_timeout, count};
   // A pop in the same cycle frees a slot, so a push into a full queue still fits.
   assign push_ok   = is_enq & ((count < DEPTH_C) | pop);
   assign push_drop = is_enq & ~push_ok;

   // Next-state logic. eng_* are loaded on the IDLE->ISSUE edge so the strobe and
   // fields appear together during ISSUE; the entry leaves the queue at the end of ISSUE.
   always_comb begin
      state_nxt  = state;
      load_issue = 1'b0;
      pop        = 1'b0;
      wait_done  = 1'b0;
      wait_tmo   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (count != 3'd0) begin
               load_issue = 1'b1;
               state_nxt  = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            // Guard against a FLUSH that emptied the queue on the way into ISSUE.
            pop       = (count != 3'd0);
            state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (eng_done) begin
               wait_done = 1'b1;
               state_nxt = ST_IDLE;
            end else if (tmo_cnt == TMO_LAST) begin
               wait_tmo  = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Queue storage needs no reset; occupancy is tracked by count and the pointers.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= entry_in;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q      <= 1'b0;
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         count        <= 3'd0;
         err_illegal  <= 1'b0;
         err_overflow <= 1'b0;
         err_timeout  <= 1'b0;
         sel_result   <= 1'b0;
         result_q     <= 8'h00;
         tmo_cnt      <= 8'h00;
         data_out     <= 8'h00;
         eng_start    <= 1'b0;
         eng_tile_i   <= 3'd0;
         eng_tile_j   <= 3'd0;
         eng_op       <= 3'd0;
         eng_operand  <= 8'h00;
      end else begin
         valid_q   <= spi_valid;
         data_out  <= sel_result ? result_q : status;
         eng_start <= load_issue;

         if (load_issue) begin
            eng_tile_i  <= head.tile_i;
            eng_tile_j  <= head.tile_j;
            eng_op      <= head.op;
            eng_operand <= head.operand;
         end

         if (push_ok) wr_ptr <= ptr_inc(wr_ptr);

         if (is_flush) begin
            count  <= 3'd0;
            rd_ptr <= wr_ptr;
         end else begin
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            count <= count + {2'b00, push_ok} - {2'b00, pop};
         end

         // Clear first so a timeout landing with CLR_ERR is not lost.
         if (is_clr) begin
            err_illegal  <= 1'b0;
            err_overflow <= 1'b0;
            err_timeout  <= 1'b0;
         end
         if (is_ill)    err_illegal  <= 1'b1;
         if (push_drop) err_overflow <= 1'b1;
         if (wait_tmo)  err_timeout  <= 1'b1;

         if (is_sel_st)  sel_result <= 1'b0;
         if (is_sel_res) sel_result <= 1'b1;

         if (state == ST_ISSUE)     tmo_cnt <= 8'h00;
         else if (state == ST_WAIT) tmo_cnt <= tmo_cnt + 8'h01;

         if (wait_done)     result_q <= eng_result;
         else if (wait_tmo) result_q <= 8'hEE;
      end
   end

endmodule

// File: doc/npu_cmd_scheduler.md
Name: npu_cmd_scheduler

Overview:
Sits in the clk domain directly behind spi_slave. It consumes each decoded SPI command (cmd/tile_i/tile_j/op_code/data_in/valid) and queues tile operations in a small FIFO. It issues queued operations one at a time to the NPU tile engine over a start/done handshake, and drives spi_slave's data_out with either a status byte or the last engine result.

Parameters:
FIFO_DEPTH, 4, operation queue entries (2..7)
TIMEOUT, 255, max clk cycles in WAIT before abort (1..255)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
spi_valid  in  1  spi_slave valid (level, already synchronised); rising edge = new command
cmd  in  8  command byte
tile_i  in  3  tile row
tile_j  in  3  tile column
op_code  in  3  engine operation
data_in  in  8  operand byte
data_out  out  8  byte returned on MISO in the next SPI frame
eng_start  out  1  one-cycle issue strobe
eng_tile_i  out  3  issued tile row
eng_tile_j  out  3  issued tile column
eng_op  out  3  issued op_code
eng_operand  out  8  issued operand
eng_done  in  1  engine completion pulse
eng_result  in  8  engine result, valid with eng_done
busy  out  1  FSM not IDLE

Behaviour:
- Reset (rst_n low at posedge): FIFO empty, all sticky errors 0, result register 0x00, select=STATUS, FSM=IDLE, timeout counter 0. Reset clears eng_start, eng_tile_i, eng_tile_j, eng_op, eng_operand and data_out to 0x00. Any in-flight operation is abandoned; a later eng_done is ignored.
- Edge detect: a registered copy of spi_valid. A command is taken in cycle E, where spi_valid=1 and the previous sample=0. Its effect is visible at E+1. A held-high spi_valid produces exactly one command.
- Command decode (cmd):
  - 0x01 ENQUEUE: push {tile_i, tile_j, op_code, data_in}.
  - 0x02 SEL_STATUS: select=STATUS.
  - 0x03 SEL_RESULT: select=RESULT.
  - 0x04 FLUSH: count=0. An in-flight WAIT operation is not aborted.
  - 0x05 CLR_ERR: clear all sticky errors.
  - Any other value: set err_illegal; no other effect.
- FIFO:
  - Push is accepted if count<FIFO_DEPTH, or if a pop happens in the same cycle. Otherwise the entry is dropped and err_overflow is set.
  - Pointers wrap modulo FIFO_DEPTH.
  - FLUSH in the same cycle as a pop gives count=0.
- Status byte: [7] busy, [6] full, [5] err_illegal, [4] err_overflow, [3] err_timeout, [2:0] count.
- data_out is registered and reloaded every cycle from the selected source: live status or the result register. The first cycle after reset gives 0x00 (status with everything clear).
- FSM:
  - IDLE: if count>0, go to ISSUE next cycle.
  - ISSUE (exactly 1 cycle):
    - eng_start=1.
    - The head entry is registered onto the eng_* fields and popped.
    - Timeout counter cleared; go to WAIT.
  - WAIT: timeout counter increments each cycle.
    - If eng_done: result register=eng_result; go to IDLE.
    - Else, if counter reaches TIMEOUT: result register=0xEE, set err_timeout, go to IDLE.
    - eng_done and timeout in the same cycle: done wins.
  - eng_done outside WAIT is ignored.
  - eng_* fields hold their values until the next ISSUE.
- Latency: ENQUEUE taken at E into an empty FIFO with FSM IDLE gives count=1 at E+1 and eng_start=1 at E+2. Back-to-back issue: eng_done at D gives IDLE at D+1 and ISSUE at D+2 if count>0.

Test Plan:
- Reset then idle → data_out=0x00, busy=0, eng_start never asserted.
- ENQUEUE tile_i=3, tile_j=5, op=2, data_in=0xA7, then engine returns 0x5C after 10 cycles, then SEL_RESULT:
  - eng_start pulses once at E+2 with fields 3/5/2/0xA7.
  - busy=1 until done+1.
  - data_out=0x5C.
- Six ENQUEUEs with eng_done held low:
  - One issued, four queued, sixth dropped.
  - Status = busy + full + err_overflow + count=4 (0xD4).
  - CLR_ERR clears err_overflow (0xC4).
- No eng_done, TIMEOUT=255 → return to IDLE exactly 255 cycles after entering WAIT; result 0xEE; err_timeout=1.
- cmd=0x7F → err_illegal=1, FIFO unchanged. spi_valid held high 20 cycles → single command.
- Two queued ops, FLUSH during WAIT → the in-flight op still completes; count=0; no further eng_start. Also assert rst_n mid-WAIT, then a late eng_done → result stays 0x00.
